// File: rtl/pc_seq_unit.sv
// PC sequencer: boot hold, fetch request handshake, writeback commit, trap redirect with flush.
// Optional PC_SEQ_ALIGN_CHECK_EN adds word alignment of loaded PCs and a misalign_o pulse.
module pc_seq_unit #(
   parameter int unsigned PC_W        = 32,
   parameter logic [31:0] RESET_PC    = 32'h8000_0000,
   parameter int unsigned BOOT_CYCLES = 2,
   parameter int unsigned CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   output logic [PC_W-1:0]  pc_o,
   output logic             pc_valid_o,
   input  logic             pc_ready_i,
   input  logic             wb_en,
   input  logic [PC_W-1:0]  npc_i,
   input  logic             trap_i,
   input  logic [PC_W-1:0]  trap_vec_i,
   output logic             flush_o,
   output logic [CNT_W-1:0] retired_o,
   output logic [1:0]       state_o
`ifdef PC_SEQ_ALIGN_CHECK_EN
   ,
   output logic             misalign_o
`endif
);

   localparam int unsigned BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

   typedef enum logic [1:0] {BOOT = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_e;

   state_e           state_q, state_d;
   logic [BW-1:0]    cnt_q, cnt_d;
   logic [PC_W-1:0]  pc_q, pc_d;
   logic [CNT_W-1:0] ret_q, ret_d;
   logic             flush_q, flush_d;
   logic             mis_q, mis_d;
   logic             trap_take, commit, load_en;
   logic [PC_W-1:0]  load_val;

   // Trap wins over both the handshake and a simultaneous commit.
   assign trap_take = trap_i && ((state_q == REQ) || (state_q == WAIT));
   assign commit    = !trap_i && (state_q == WAIT) && wb_en;
   assign load_en   = trap_take || commit;
   assign load_val  = trap_i ? trap_vec_i : npc_i;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pc_d    = pc_q;
      ret_d   = ret_q;
      flush_d = 1'b0;
      mis_d   = 1'b0;
      case (state_q)
         BOOT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == BOOT_LAST) state_d = REQ;
         end
         REQ: begin
            if (trap_take)       state_d = REQ;
            else if (pc_ready_i) state_d = WAIT;
         end
         WAIT: begin
            if (load_en) state_d = REQ;
         end
         default: state_d = REQ;
      endcase
      if (load_en) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
         pc_d  = {load_val[PC_W-1:2], 2'b00};
         mis_d = |load_val[1:0];
`else
         pc_d  = load_val;
`endif
         flush_d = trap_take;
      end
      if (commit) ret_d = ret_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= BOOT;
         cnt_q   <= '0;
         pc_q    <= PC_W'(RESET_PC);
         ret_q   <= '0;
         flush_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pc_q    <= pc_d;
         ret_q   <= ret_d;
         flush_q <= flush_d;
         mis_q   <= mis_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_valid_o = (state_q == REQ);
   assign flush_o    = flush_q;
   assign retired_o  = ret_q;
   assign state_o    = state_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
   assign misalign_o = mis_q;
`else
   logic unused_mis;
   assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_pc_seq_unit.sv
// Self-checking bench for pc_seq_unit: directed scenarios plus randomized traffic against a cycle model.
module tb_pc_seq_unit;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] pc;
   logic        valid;
   logic        ready = 1'b0;
   logic        wb = 1'b0;
   logic [31:0] npc = '0;
   logic        trap = 1'b0;
   logic [31:0] vec = '0;
   logic        flush;
   logic [3:0]  retired;
   logic [1:0]  state;
   logic        mis;

   int checks = 0;
   int errors = 0;

   // Reference model: remaining boot cycles, whether a commit is awaited, and architectural values.
   logic [31:0] m_pc;
   int          m_ret;
   int          m_boot_left;
   bit          m_wait;
   bit          m_flush;
   bit          m_mis;

   pc_seq_unit #(
      .PC_W(32), .RESET_PC(32'h8000_0000), .BOOT_CYCLES(2), .CNT_W(4)
   ) dut (
      .clk_i(clk), .rst_i(rst_n), .pc_o(pc), .pc_valid_o(valid), .pc_ready_i(ready),
      .wb_en(wb), .npc_i(npc), .trap_i(trap), .trap_vec_i(vec), .flush_o(flush),
      .retired_o(retired), .state_o(state)
`ifdef PC_SEQ_ALIGN_CHECK_EN
      , .misalign_o(mis)
`endif
   );

`ifndef PC_SEQ_ALIGN_CHECK_EN
   assign mis = 1'b0;
`endif

   always #5 clk = ~clk;

   function automatic logic [31:0] fix(input logic [31:0] v);
`ifdef PC_SEQ_ALIGN_CHECK_EN
      return v & 32'hFFFF_FFFC;
`else
      return v;
`endif
   endfunction

   function automatic logic [1:0] exp_state();
      if (m_boot_left > 0) return 2'd0;
      return m_wait ? 2'd2 : 2'd1;
   endfunction

   task automatic model_reset();
      m_pc = RST_PC; m_ret = 0; m_boot_left = 2; m_wait = 0; m_flush = 0; m_mis = 0;
   endtask

   task automatic model_edge();
      m_flush = 0;
      m_mis   = 0;
      if (m_boot_left > 0) m_boot_left--;
      else if (trap) begin
         m_pc = fix(vec); m_flush = 1; m_mis = (vec[1:0] != 2'b00); m_wait = 0;
      end else if (!m_wait) begin
         if (ready) m_wait = 1;
      end else if (wb) begin
         m_pc = fix(npc); m_mis = (npc[1:0] != 2'b00); m_ret = (m_ret + 1) % 16; m_wait = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; ready = 0; wb = 0; trap = 0;
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      checks += 5;
      if (pc !== RST_PC) begin errors++; $display("FAIL reset_pc got %h want %h", pc, RST_PC); end
      if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", flush); end
      if (retired !== 4'd0) begin errors++; $display("FAIL reset_retired got %0d want 0", retired); end
      if (state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
      rst_n = 1'b1;
      trap = 1; wb = 1;
      tick();
      checks += 2;
      if (valid !== 1'b0) begin errors++; $display("FAIL boot1_valid got %b want 0", valid); end
      if (pc !== RST_PC) begin errors++; $display("FAIL boot1_pc got %h want %h", pc, RST_PC); end
      tick();
      trap = 0; wb = 0;
      checks += 3;
      if (valid !== 1'b1) begin errors++; $display("FAIL boot2_valid got %b want 1", valid); end
      if (state !== 2'd1) begin errors++; $display("FAIL boot2_state got %0d want 1", state); end
      if (pc !== RST_PC) begin errors++; $display("FAIL boot2_pc got %h want %h", pc, RST_PC); end
   endtask

   task automatic test_commit();
      ready = 1;
      tick();
      ready = 0;
      checks += 2;
      if (state !== 2'd2) begin errors++; $display("FAIL hs_state got %0d want 2", state); end
      if (valid !== 1'b0) begin errors++; $display("FAIL hs_valid got %b want 0", valid); end
      wb = 1; npc = 32'h8000_0004;
      tick();
      wb = 0;
      checks += 3;
      if (pc !== 32'h8000_0004) begin errors++; $display("FAIL commit_pc got %h want 80000004", pc); end
      if (valid !== 1'b1) begin errors++; $display("FAIL commit_valid got %b want 1", valid); end
      if (retired !== 4'd1) begin errors++; $display("FAIL commit_retired got %0d want 1", retired); end
      wb = 1; npc = 32'h1234_5678;
      tick();
      wb = 0;
      checks += 2;
      if (pc !== 32'h8000_0004) begin errors++; $display("FAIL wb_in_req_pc got %h want 80000004", pc); end
      if (retired !== 4'd1) begin errors++; $display("FAIL wb_in_req_ret got %0d want 1", retired); end
   endtask

   task automatic test_trap_with_wb();
      ready = 1;
      tick();
      ready = 0;
      trap = 1; vec = 32'h8000_1000; wb = 1; npc = 32'h8000_0008;
      tick();
      trap = 0; wb = 0;
      checks += 4;
      if (pc !== 32'h8000_1000) begin errors++; $display("FAIL trap_pc got %h want 80001000", pc); end
      if (flush !== 1'b1) begin errors++; $display("FAIL trap_flush got %b want 1", flush); end
      if (retired !== 4'd1) begin errors++; $display("FAIL trap_retired got %0d want 1", retired); end
      if (state !== 2'd1) begin errors++; $display("FAIL trap_state got %0d want 1", state); end
      tick();
      checks += 1;
      if (flush !== 1'b0) begin errors++; $display("FAIL trap_flush_end got %b want 0", flush); end
   endtask

   task automatic test_stall();
      logic [31:0] held;
      held = pc;
      ready = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks += 3;
         if (valid !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", valid); end
         if (pc !== held) begin errors++; $display("FAIL stall_pc got %h want %h", pc, held); end
         if (state !== 2'd1) begin errors++; $display("FAIL stall_state got %0d want 1", state); end
      end
   endtask

   task automatic test_back_to_back_traps();
      ready = 1;
      for (int i = 0; i < 3; i++) begin
         trap = 1; vec = $urandom;
         tick();
         checks += 2;
         if (pc !== m_pc) begin errors++; $display("FAIL b2b_pc got %h want %h", pc, m_pc); end
         if (flush !== 1'b1) begin errors++; $display("FAIL b2b_flush got %b want 1", flush); end
      end
      trap = 0; ready = 0;
      tick();
      checks += 1;
      if (flush !== 1'b0) begin errors++; $display("FAIL b2b_flush_end got %b want 0", flush); end
   endtask

   task automatic test_wrap_and_reset();
      do_reset();
      tick(); tick();
      for (int i = 0; i < 16; i++) begin
         ready = 1;
         tick();
         ready = 0; wb = 1; npc = {$urandom} & 32'hFFFF_FFFC;
         tick();
         wb = 0;
         if (i == 14) begin
            checks += 1;
            if (retired !== 4'd15) begin errors++; $display("FAIL wrap15 got %0d want 15", retired); end
         end
      end
      checks += 1;
      if (retired !== 4'd0) begin errors++; $display("FAIL wrap0 got %0d want 0", retired); end
      ready = 1;
      tick();
      ready = 0;
      checks += 1;
      if (state !== 2'd2) begin errors++; $display("FAIL pre_rst_state got %0d want 2", state); end
      rst_n = 1'b0;
      model_reset();
      #1;
      checks += 5;
      if (pc !== RST_PC) begin errors++; $display("FAIL midrst_pc got %h want %h", pc, RST_PC); end
      if (valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", valid); end
      if (flush !== 1'b0) begin errors++; $display("FAIL midrst_flush got %b want 0", flush); end
      if (retired !== 4'd0) begin errors++; $display("FAIL midrst_retired got %0d want 0", retired); end
      if (state !== 2'd0) begin errors++; $display("FAIL midrst_state got %0d want 0", state); end
      rst_n = 1'b1;
   endtask

`ifdef PC_SEQ_ALIGN_CHECK_EN
   task automatic test_misalign();
      do_reset();
      tick(); tick();
      ready = 1;
      tick();
      ready = 0; wb = 1; npc = 32'h8000_0006;
      tick();
      wb = 0;
      checks += 2;
      if (pc !== 32'h8000_0004) begin errors++; $display("FAIL mis_pc got %h want 80000004", pc); end
      if (mis !== 1'b1) begin errors++; $display("FAIL mis_pulse got %b want 1", mis); end
      tick();
      checks += 1;
      if (mis !== 1'b0) begin errors++; $display("FAIL mis_end got %b want 0", mis); end
   endtask
`endif

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         ready = 1'($urandom_range(0, 1));
         wb    = ($urandom % 3) == 0;
         trap  = ($urandom % 8) == 0;
         npc   = $urandom;
         vec   = $urandom;
         tick();
         checks += 6;
         if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h want %h", i, pc, m_pc); end
         if (valid !== (m_boot_left == 0 && !m_wait)) begin errors++; $display("FAIL rnd_valid cyc %0d got %b", i, valid); end
         if (flush !== m_flush) begin errors++; $display("FAIL rnd_flush cyc %0d got %b want %b", i, flush, m_flush); end
         if (retired !== 4'(m_ret)) begin errors++; $display("FAIL rnd_retired cyc %0d got %0d want %0d", i, retired, m_ret); end
         if (state !== exp_state()) begin errors++; $display("FAIL rnd_state cyc %0d got %0d want %0d", i, state, exp_state()); end
`ifdef PC_SEQ_ALIGN_CHECK_EN
         if (mis !== m_mis) begin errors++; $display("FAIL rnd_mis cyc %0d got %b want %b", i, mis, m_mis); end
`else
         if (mis !== 1'b0) begin errors++; $display("FAIL rnd_mis cyc %0d got %b want 0", i, mis); end
`endif
      end
      ready = 0; wb = 0; trap = 0;
   endtask

   initial begin
      @(posedge clk);
      #1;
      test_reset();
      test_commit();
      test_trap_with_wb();
      test_stall();
      test_back_to_back_traps();
      test_wrap_and_reset();
`ifdef PC_SEQ_ALIGN_CHECK_EN
      test_misalign();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_seq_unit.md
Name: pc_seq_unit

Overview:
- Parametrised PC sequencer for the multi-cycle core; successor to the basic PC register.
- Holds the architectural PC and drives it to the fetch unit with a valid/ready handshake.
- Waits for the writeback commit before loading the next PC; traps redirect it.
- Adds a boot-hold counter, a trap/flush path and a retired-instruction counter.

Parameters:
- PC_W, 32, width of PC and all address ports.
- RESET_PC, 32'h8000_0000, PC value loaded on reset, truncated to PC_W.
- BOOT_CYCLES, 2, cycles spent in BOOT after reset release before the first fetch request (≥1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- pc_o  out  PC_W  current PC.
- pc_valid_o  out  1  PC request valid to fetch.
- pc_ready_i  in  1  fetch accepts pc_o.
- wb_en  in  1  writeback commit of the current instruction.
- npc_i  in  PC_W  next PC from writeback, sampled when wb_en is accepted.
- trap_i  in  1  trap/exception redirect request.
- trap_vec_i  in  PC_W  trap target, sampled with trap_i.
- flush_o  out  1  one-cycle pulse telling fetch/decode to drop in-flight work.
- retired_o  out  CNT_W  count of committed instructions.
- state_o  out  2  encoded FSM state, for debug.

Behaviour:
- Reset (rst_i=0, async): state goes to BOOT and the boot counter loads 0.
- Output reset values: pc_o=RESET_PC, pc_valid_o=0, flush_o=0, retired_o=0.
- State encoding: BOOT=0, REQ=1, WAIT=2. Encoding 3 is unreachable and recovers to REQ on the next edge.
- BOOT:
  - pc_valid_o=0; the counter increments each cycle.
  - When counter==BOOT_CYCLES-1, the next state is REQ.
  - trap_i and wb_en are ignored.
- REQ:
  - pc_valid_o=1 combinationally from state; pc_o holds stable.
  - On pc_valid_o&&pc_ready_i, the next state is WAIT.
  - wb_en in REQ is ignored (protocol violation; no state change, no count).
- WAIT:
  - pc_valid_o=0.
  - On wb_en: pc_o<=npc_i, retired_o<=retired_o+1, next state is REQ. This is a 1-cycle latency from commit to the new request.
- Trap (in REQ or WAIT):
  - pc_o<=trap_vec_i, flush_o=1 on the following cycle only, next state is REQ.
  - Trap has priority over wb_en and over the handshake. If the handshake fires in the same cycle, fetch still saw the old PC, and the flush_o pulse cancels it.
  - retired_o is not incremented on trap, even with simultaneous wb_en.
  - Back-to-back traps: each loads the newest trap_vec_i; flush_o stays high while traps continue.
- retired_o wraps modulo 2^CNT_W with no saturation and no flag.
- npc_i and trap_vec_i are used at full PC_W width with no alignment masking, unless the optional feature below is enabled.
- Reset mid-operation: immediate return to reset values regardless of state; any pending flush is discarded.

Optional Feature:
- Macro: PC_SEQ_ALIGN_CHECK_EN.
- When defined:
  - Adds output misalign_o (1 bit, reset 0).
  - If a loaded npc_i or trap_vec_i has bits[1:0]!=0, pc_o takes the value with bits[1:0] forced to 0.
  - misalign_o pulses high for exactly one cycle, aligned with the first REQ cycle of that PC.
  - A misaligned trap_vec_i also sets misalign_o.
- When undefined: no misalign_o port; values load unmodified.

Test Plan:
- Reset release with BOOT_CYCLES=2 → pc_o=32'h8000_0000, pc_valid_o=0 for 2 cycles, then pc_valid_o=1.
- REQ, pc_ready_i=1 → WAIT; wb_en=1 with npc_i=32'h8000_0004 → next cycle pc_o=32'h8000_0004, pc_valid_o=1, retired_o=1.
- In WAIT, trap_i=1 with trap_vec_i=32'h8000_1000 and wb_en=1 in the same cycle → pc_o=32'h8000_1000, flush_o=1 for one cycle, retired_o unchanged.
- Hold pc_ready_i=0 for 5 cycles in REQ → pc_valid_o stays 1, pc_o stable, state_o=1.
- CNT_W=4, commit 16 instructions → retired_o wraps to 0. Assert rst_i low mid-WAIT → all outputs at reset values immediately, without waiting for a clock edge.
- With PC_SEQ_ALIGN_CHECK_EN, npc_i=32'h8000_0006 → pc_o=32'h8000_0004 and misalign_o pulses 1 for one cycle.
